// File: rtl/mdu_pkg.sv
// Shared MDU definitions: funct encodings and FSM state type.
package mdu_pkg;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] t;
   logic [WIDTH:0] diff;

   assign t     = {rem_i, bit_i};
   assign diff  = t - {1'b0, div_i};
   // rem_i < div_i, so a non-negative diff always fits in WIDTH bits
   assign q_o   = ~diff[WIDTH];
   assign rem_o = q_o ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int N_MUL = WIDTH / MUL_STEP;
   localparam int CW    = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

   mdu_state_t         state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               sa_q;
   logic               sb_q;
   logic               isdiv_q;
   logic               divz_q;
   logic               done_q;
   logic               dbz_q;

   logic             is_mul;
   logic             is_div;
   logic             sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   assign is_mul = start && (funct == F_MULT || funct == F_MULTU);
   assign is_div = start && (funct == F_DIV || funct == F_DIVU);
   assign sgn    = (funct == F_MULT) || (funct == F_DIV);
   assign a_neg  = sgn & srca[WIDTH-1];
   assign b_neg  = sgn & srcb[WIDTH-1];
   assign mag_a  = a_neg ? -srca : srca;
   assign mag_b  = b_neg ? -srcb : srcb;

   // acc_q holds {partial product, remaining multiplier bits} while multiplying
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     mul_sum;

   always_comb begin
      mul_acc = acc_q;
      mul_sum = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         mul_sum = {1'b0, mul_acc[2*WIDTH-1:WIDTH]}
                 + (mul_acc[0] ? {1'b0, opb_q} : '0);
         mul_acc = {mul_sum, mul_acc[WIDTH-1:1]};
      end
   end

   logic [WIDTH-1:0] div_rem;
   logic             div_qb;

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_i (acc_q[2*WIDTH-1:WIDTH]),
      .div_i (opb_q),
      .bit_i (acc_q[WIDTH-1]),
      .rem_o (div_rem),
      .q_o   (div_qb)
   );

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo    = acc_q[WIDTH-1:0];
      rem    = acc_q[2*WIDTH-1:WIDTH];
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (isdiv_q) begin
         fix_hi = sa_q ? -rem : rem;
         fix_lo = divz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         isdiv_q <= 1'b0;
         divz_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               sa_q  <= a_neg;
               sb_q  <= b_neg;
               if (is_mul) begin
                  state_q <= MUL;
                  acc_q   <= {{WIDTH{1'b0}}, mag_b};
                  opb_q   <= mag_a;
                  isdiv_q <= 1'b0;
                  divz_q  <= 1'b0;
               end else if (is_div) begin
                  state_q <= DIV;
                  acc_q   <= {{WIDTH{1'b0}}, mag_a};
                  opb_q   <= mag_b;
                  isdiv_q <= 1'b1;
                  divz_q  <= (srcb == '0);
               end else if (start && funct == F_MTHI) begin
                  hi_q <= srca;
               end else if (start && funct == F_MTLO) begin
                  lo_q <= srca;
               end
            end
            MUL: begin
               acc_q <= mul_acc;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == MUL_LAST) state_q <= FIX;
            end
            DIV: begin
               acc_q <= {div_rem, acc_q[WIDTH-2:0], div_qb};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == DIV_LAST) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               done_q  <= 1'b1;
               dbz_q   <= divz_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      result = '0;
      if (funct == F_MFHI) result = hi_q;
      else if (funct == F_MFLO) result = lo_q;
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit (MUL_STEP=1 and MUL_STEP=4 instances).
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] srca = '0;
   logic [31:0] srcb = '0;
   logic        busy, done, dbz;
   logic [31:0] hi, lo, result;

   logic        start4 = 1'b0;
   logic [5:0]  funct4 = '0;
   logic [31:0] srca4 = '0;
   logic [31:0] srcb4 = '0;
   logic        busy4, done4, dbz4;
   logic [31:0] hi4, lo4, result4;

   always #5 clk = ~clk;

   mdu_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
      .clk(clk), .reset(reset), .start(start), .funct(funct),
      .srca(srca), .srcb(srcb), .busy(busy), .done(done),
      .div_by_zero(dbz), .hi(hi), .lo(lo), .result(result)
   );

   mdu_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .funct(funct4),
      .srca(srca4), .srcb(srcb4), .busy(busy4), .done(done4),
      .div_by_zero(dbz4), .hi(hi4), .lo(lo4), .result(result4)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t sbq[$];

   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input int n_mul);
      exp_t e;
      longint p;
      logic [63:0] u;
      int sa, sb;
      e.hi = '0; e.lo = '0; e.dz = 1'b0; e.cyc = 33;
      sa = a; sb = b;
      case (f)
         F_MULT: begin
            p = longint'(sa) * longint'(sb);
            e.hi = p[63:32]; e.lo = p[31:0]; e.cyc = n_mul + 1;
         end
         F_MULTU: begin
            u = {32'b0, a} * {32'b0, b};
            e.hi = u[63:32]; e.lo = u[31:0]; e.cyc = n_mul + 1;
         end
         F_DIV: begin
            if (b == 0) begin
               e.hi = a; e.lo = '1; e.dz = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.hi = '0; e.lo = a;
            end else begin
               e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
            end
         end
         F_DIVU: begin
            if (b == 0) begin
               e.hi = a; e.lo = '1; e.dz = 1'b1;
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic run_op(input bit s4, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit intr);
      exp_t e;
      int   cnt;
      bit   got;
      sbq.push_back(model(f, a, b, s4 ? 8 : 32));
      @(negedge clk);
      if (s4) begin
         start4 = 1'b1; funct4 = f; srca4 = a; srcb4 = b;
      end else begin
         start = 1'b1; funct = f; srca = a; srcb = b;
      end
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      srca = $urandom; srcb = $urandom;
      srca4 = $urandom; srcb4 = $urandom;
      cnt = 0; got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (s4 ? done4 : done) begin
            got = 1'b1;
            break;
         end
         if (s4 ? busy4 : busy) cnt++;
         if (intr && i == 3) begin
            start = 1'b1; funct = F_DIV; srca = 9; srcb = 3;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      e = sbq.pop_front();
      if (!got) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("hi", s4 ? hi4 : hi, e.hi);
         chk("lo", s4 ? lo4 : lo, e.lo);
         chk("div_by_zero", s4 ? dbz4 : dbz, e.dz);
         chk("busy_cycles", cnt, e.cyc);
         chk("busy_at_done", s4 ? busy4 : busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", dbz, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(negedge clk);
      reset = 1'b1;

      run_op(0, F_MULT, 32'hFFFFFFFD, 32'd5, 0);
      chk("t1_hi", hi, 32'hFFFFFFFF);
      chk("t1_lo", lo, 32'hFFFFFFF1);
      run_op(0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      chk("t2_hi", hi, 32'hFFFFFFFE);
      chk("t2_lo", lo, 32'h00000001);
      run_op(0, F_DIV, 32'hFFFFFFF9, 32'd2, 0);
      run_op(0, F_DIVU, 32'd7, 32'd2, 0);
      run_op(0, F_DIV, 32'h10, 32'd0, 0);
      run_op(0, F_DIVU, 32'h80000001, 32'd0, 0);
      run_op(0, F_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
      run_op(0, F_MULT, 32'h80000000, 32'h80000000, 0);
      run_op(0, F_DIV, 32'd100, 32'd7, 1);

      for (int k = 0; k < 8; k++) begin
         logic [5:0]  fr;
         logic [31:0] b;
         case ($urandom_range(0, 3))
            0: fr = F_MULT;
            1: fr = F_MULTU;
            2: fr = F_DIV;
            default: fr = F_DIVU;
         endcase
         b = (k == 5) ? 32'd0 : $urandom;
         if (k[0]) b = b >> $urandom_range(0, 28);
         run_op(0, fr, $urandom, b, 0);
      end

      @(negedge clk);
      start = 1'b1; funct = F_MTHI; srca = 32'h1234;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_busy", busy, 0);
      chk("mthi_done", done, 0);
      funct = F_MFHI; #1;
      chk("mfhi_result", result, 32'h1234);
      @(negedge clk);
      start = 1'b1; funct = F_MTLO; srca = 32'h5678;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo_lo", lo, 32'h5678);
      chk("mtlo_hi_kept", hi, 32'h1234);
      funct = F_MFLO; #1;
      chk("mflo_result", result, 32'h5678);
      funct = F_MULT; #1;
      chk("other_result", result, 0);

      @(negedge clk);
      start = 1'b1; funct = F_DIV; srca = 32'd1000; srcb = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_done", done, 0);
      @(negedge clk);
      reset = 1'b1;
      run_op(0, F_MULT, 32'd12345, 32'hFFFFFF00, 0);

      run_op(1, F_MULT, 32'hFFFFFFFD, 32'd5, 0);
      chk("t6_hi4", hi4, 32'hFFFFFFFF);
      chk("t6_lo4", lo4, 32'hFFFFFFF1);
      run_op(1, F_MULTU, 32'hDEADBEEF, 32'hCAFEF00D, 0);
      run_op(1, F_DIV, 32'hFFFFFF9C, 32'd7, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
